// File: rtl/ov7670_frame_capture.sv
// ov7670_frame_capture
//   Captures RGB565 frames from an OV7670 byte bus, packs each pixel to
//   RGB444 and writes it to a frame buffer at address line*H_PIX + pixel.
//   Capture is frame-aligned: a frame is only taken after a full vertical
//   blanking interval has been observed, so enabling mid-frame never yields
//   a partial picture.
//
// Parameters
//   H_PIX    active pixels per line
//   V_LINES  active lines per frame
//   ADDR_W   frame-buffer address width
//
// Ports
//   pclk         camera pixel clock (sole clock)
//   reset        synchronous reset, active low
//   href         line valid
//   vsync        frame sync, high during vertical blanking
//   ov7670_data  byte bus, two bytes per RGB565 pixel
//   cap_en       capture enable level
//   we           write strobe, one cycle per stored pixel
//   wAddr        write address
//   wData        RGB444 pixel {R,G,B}
//   frame_done   one-cycle pulse at the end of each captured frame
//   frame_err    geometry error of the last completed frame
//   busy         high while waiting for frame start or capturing
module ov7670_frame_capture #(
    parameter int H_PIX   = 320,
    parameter int V_LINES = 240,
    parameter int ADDR_W  = 17
) (
    input  logic              pclk,
    input  logic              reset,
    input  logic              href,
    input  logic              vsync,
    input  logic [7:0]        ov7670_data,
    input  logic              cap_en,
    output logic              we,
    output logic [ADDR_W-1:0] wAddr,
    output logic [11:0]       wData,
    output logic              frame_done,
    output logic              frame_err,
    output logic              busy
);

    // Counters saturate one past the legal maximum so an overlong line or
    // frame is still distinguishable from an exact one.
    localparam int PIX_W  = $clog2(H_PIX + 2);
    localparam int LINE_W = $clog2(V_LINES + 2);

    localparam logic [PIX_W-1:0]  PIX_MAX  = PIX_W'(H_PIX);
    localparam logic [PIX_W-1:0]  PIX_SAT  = PIX_W'(H_PIX + 1);
    localparam logic [LINE_W-1:0] LINE_MAX = LINE_W'(V_LINES);
    localparam logic [LINE_W-1:0] LINE_SAT = LINE_W'(V_LINES + 1);
    localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(H_PIX);

    typedef enum logic [1:0] {IDLE, SYNC, ACTIVE, DONE} state_t;

    state_t state_q, state_d;

    logic [PIX_W-1:0]  pix_cnt;
    logic [LINE_W-1:0] line_cnt;
    logic [ADDR_W-1:0] line_base;   // line_cnt*H_PIX, built by repeated add
    logic              phase;       // 1 = first byte of a pixel is pending
    logic [6:0]        b1;          // only the first-byte bits that survive packing
    logic              href_d;
    logic              err_acc;

    always_ff @(posedge pclk) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        frame_done = 1'b0;
        busy       = 1'b0;
        case (state_q)
            IDLE: begin
                // Only arm during blanking so capture never starts mid-frame.
                if (cap_en && vsync) state_d = SYNC;
            end
            SYNC: begin
                busy = 1'b1;
                if (!vsync) state_d = ACTIVE;
            end
            ACTIVE: begin
                busy = 1'b1;
                if (vsync) state_d = DONE;
            end
            DONE: begin
                frame_done = 1'b1;
                state_d    = cap_en ? SYNC : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (!reset) begin
            we        <= 1'b0;
            wAddr     <= '0;
            wData     <= '0;
            frame_err <= 1'b0;
            pix_cnt   <= '0;
            line_cnt  <= '0;
            line_base <= '0;
            phase     <= 1'b0;
            b1        <= '0;
            href_d    <= 1'b0;
            err_acc   <= 1'b0;
        end else begin
            we     <= 1'b0;
            href_d <= href;
            if (state_q == SYNC && !vsync) begin
                pix_cnt   <= '0;
                line_cnt  <= '0;
                line_base <= '0;
                err_acc   <= 1'b0;
                phase     <= 1'b0;
            end else if (state_q == ACTIVE) begin
                if (href) begin
                    phase <= ~phase;
                    if (!phase) begin
                        b1 <= {ov7670_data[7:4], ov7670_data[2:0]};
                    end else begin
                        if (pix_cnt < PIX_MAX && line_cnt < LINE_MAX) begin
                            we    <= 1'b1;
                            wAddr <= line_base + ADDR_W'(pix_cnt);
                            wData <= {b1, ov7670_data[7], ov7670_data[4:1]};
                        end
                        if (pix_cnt != PIX_SAT) pix_cnt <= pix_cnt + 1'b1;
                    end
                end else begin
                    phase <= 1'b0;
                    if (href_d) begin
                        // End of line: wrong width or a dangling half pixel.
                        if (pix_cnt != PIX_MAX || phase) err_acc <= 1'b1;
                        pix_cnt <= '0;
                        if (line_cnt != LINE_SAT) line_cnt <= line_cnt + 1'b1;
                        if (line_cnt < LINE_MAX) line_base <= line_base + LINE_STEP;
                    end
                end
                // Latched on entry to DONE so it is valid alongside frame_done.
                if (vsync) frame_err <= err_acc | (line_cnt != LINE_MAX);
            end else begin
                phase <= 1'b0;
            end
        end
    end

endmodule

// File: doc/ov7670_frame_capture.md
OV7670_FRAME_CAPTURE -- requirements
Module: ov7670_frame_capture

Interface
REQ-001 The block SHALL have parameter H_PIX, default 320, meaning pixels per active line.
REQ-002 The block SHALL have parameter V_LINES, default 240, meaning active lines per frame.
REQ-003 The block SHALL have parameter ADDR_W, default 17, meaning frame-buffer write address width.
REQ-004 Port pclk, input, 1, camera pixel clock; the only clock.
REQ-005 Port reset, input, 1, synchronous active-low reset (0 = reset), sampled on pclk rising edge.
REQ-006 Port href, input, 1, camera line-valid.
REQ-007 Port vsync, input, 1, camera frame sync; high = vertical blanking.
REQ-008 Port ov7670_data, input, 8, camera byte bus, RGB565 two bytes per pixel.
REQ-009 Port cap_en, input, 1, capture enable level.
REQ-010 Port we, output, 1, frame-buffer write strobe.
REQ-011 Port wAddr, output, ADDR_W, frame-buffer write address.
REQ-012 Port wData, output, 12, RGB444 pixel {R[3:0],G[3:0],B[3:0]}.
REQ-013 Port frame_done, output, 1, one-cycle pulse at end of each captured frame.
REQ-014 Port frame_err, output, 1, geometry error flag for the last completed frame.
REQ-015 Port busy, output, 1, high while in SYNC or ACTIVE.

Function
REQ-016 The FSM SHALL have states IDLE, SYNC, ACTIVE, DONE.
REQ-017 IDLE->SYNC when cap_en=1 and vsync=1; if vsync=0 in IDLE, the FSM SHALL remain in IDLE, never starting mid-frame.
REQ-018 SYNC->ACTIVE on the first cycle vsync is sampled 0 after being 1; line counter, pixel counter, address and error accumulator SHALL clear on this transition.
REQ-019 ACTIVE->DONE when vsync is sampled 1; cap_en deasserted mid-frame SHALL NOT abort the frame.
REQ-020 DONE SHALL last exactly one cycle, with frame_done=1; next state SYNC if cap_en=1, else IDLE.
REQ-021 Writes SHALL occur only in ACTIVE with href=1; bytes outside href SHALL be ignored.
REQ-022 A byte-phase toggle SHALL clear to 0 whenever href=0, so each line starts on the first byte.
REQ-023 Phase 0 byte SHALL be latched; on phase 1, wData SHALL be {b1[7:4], b1[2:0], b2[7], b2[4:1]} (b1 first byte, b2 second byte).
REQ-024 we SHALL be a registered one-cycle pulse in the cycle after the second byte is sampled, with wAddr/wData valid in that cycle.
REQ-025 wAddr SHALL equal line*H_PIX + pixel, generated by increment (no multiplier), starting at 0 each frame.
REQ-026 Pixels with column >= H_PIX or line >= V_LINES SHALL NOT assert we; wAddr SHALL never exceed H_PIX*V_LINES-1.
REQ-027 The line counter SHALL increment on each href falling edge in ACTIVE; the pixel counter SHALL clear at that edge.
REQ-028 An error SHALL accumulate when a line ends with pixel count != H_PIX, or when href falls while a phase-0 byte is pending.
REQ-029 At the DONE cycle, an error SHALL also accumulate if line count != V_LINES; frame_err SHALL update to the accumulated value in DONE and hold until the next DONE.
REQ-030 busy SHALL be 1 in SYNC and ACTIVE, and 0 in IDLE and DONE.

Reset
REQ-031 With reset=0 on a pclk edge, the FSM SHALL enter IDLE and we, wAddr, wData, frame_done, frame_err, busy, counters and byte phase SHALL become 0.
REQ-032 Reset asserted mid-frame SHALL drop we in the next cycle; no write from the interrupted frame SHALL occur after reset release.

Verification
REQ-033 Nominal: cap_en=1; full frame of 240 lines x 640 bytes -> 76800 we pulses, wAddr 0..76799 in order, one frame_done, frame_err=0.
REQ-034 Color pack: bytes 0xF8,0x1F -> wData=0xF0F; bytes 0x07,0xE0 -> wData=0x0F0.
REQ-035 Short line: line 10 carries 638 bytes -> 319 writes on that line, frame_err=1 at frame_done; next clean frame -> frame_err=0.
REQ-036 Late enable: cap_en rises while vsync=0 mid-frame -> no we until after the next vsync high-then-low; then a full frame is captured from wAddr 0.
REQ-037 Overlong frame: 250 lines of 700 bytes -> no wAddr above 76799, no write for columns >=320 or lines >=240, frame_err=1.
REQ-038 Reset mid-frame at line 100 -> outputs 0 the next cycle; after release with cap_en=1, no writes occur until the next vsync falling edge.
